store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 170 +++++++++++++++++
 tb/tb_store_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between core and data memory: queues stores and drains them when the memory port is free.
// Optional store-to-load forwarding is compiled in when SB_FWD_EN is defined.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              CoreAddr,
    input  logic [31:0]              CoreDataWr,
    input  logic [2:0]               CoreCtrl,
    input  logic                     CoreWr,
    input  logic                     CoreRd,
    input  logic                     SBFlush,
    output logic [31:0]              CoreDataRd,
    output logic                     CoreStall,
    output logic                     SBEmpty,
    output logic [$clog2(DEPTH):0]   SBCount,
    output logic [31:0]              DMAddress,
    output logic [31:0]              DMDataWr,
    output logic                     DMWr,
    output logic [2:0]               DMCtrl,
    input  logic [31:0]              DMDataRd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [2:0]       ctrl_q [DEPTH];
    logic [2:0]       ctrl_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] scan_idx;
    logic             word_hit;
    logic             hazard;
    logic             nonempty;
    logic             full;
    logic             load_blocked;
    logic             do_store;
    logic             do_drain;
    logic             port_load;
    logic             fwd_hit;
    logic [31:0]      fwd_data;

`ifdef SB_FWD_EN
    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] c);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = d[7:0];
        h = d[15:0];
        case (c[1:0])
            2'b00:   if (c[2]) load_ext = {24'h0, b}; else load_ext = 32'(b);
            2'b01:   if (c[2]) load_ext = {16'h0, h}; else load_ext = 32'(h);
            default: load_ext = d;
        endcase
    endfunction
`endif

    // Scan oldest to youngest so the last word match wins; forwarding is only
    // safe when that youngest overlapping store is an exact address/width match.
    always_comb begin
        scan_idx = '0;
        word_hit = 1'b0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (valid_q[scan_idx] && addr_q[scan_idx][31:2] == CoreAddr[31:2]) begin
                word_hit = 1'b1;
`ifdef SB_FWD_EN
                if (addr_q[scan_idx] == CoreAddr && ctrl_q[scan_idx][1:0] == CoreCtrl[1:0]) begin
                    fwd_hit  = 1'b1;
                    fwd_data = load_ext(data_q[scan_idx], CoreCtrl);
                end else begin
                    fwd_hit  = 1'b0;
                end
`endif
            end
        end
        hazard = CoreRd & word_hit & ~fwd_hit;
    end

    // A pending fence also blocks loads so the drain can use the port and the
    // stalled load cannot starve it.
    always_comb begin
        nonempty     = (count_q != '0);
        full         = (count_q == CNT_W'(DEPTH));
        load_blocked = hazard | (SBFlush & nonempty);
        do_store     = CoreWr & ~CoreRd;
        do_drain     = nonempty & (CoreRd ? load_blocked : (~CoreWr | full | SBFlush));
        port_load    = CoreRd & ~load_blocked & ~fwd_hit;
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (do_drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (do_store) begin
            addr_d[tail_q]  = CoreAddr;
            data_d[tail_q]  = CoreDataWr;
            ctrl_d[tail_q]  = CoreCtrl;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_store) - CNT_W'(do_drain);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset; the valid bits and count qualify it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        ctrl_q <= ctrl_d;
    end

    always_comb begin
        DMAddress  = '0;
        DMDataWr   = '0;
        DMCtrl     = '0;
        DMWr       = 1'b0;
        CoreDataRd = '0;
        CoreStall  = 1'b0;
        SBCount    = '0;
        SBEmpty    = 1'b1;
        if (!rst) begin
            SBCount   = count_q;
            SBEmpty   = ~nonempty;
            CoreStall = (CoreRd & hazard) | (SBFlush & nonempty);
            if (do_drain) begin
                DMAddress = addr_q[head_q];
                DMDataWr  = data_q[head_q];
                DMCtrl    = ctrl_q[head_q];
                DMWr      = 1'b1;
            end else if (port_load) begin
                DMAddress = CoreAddr;
                DMCtrl    = CoreCtrl;
            end
            if (CoreRd && !load_blocked) begin
                CoreDataRd = fwd_hit ? fwd_data : DMDataRd;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic checked against a queue-based model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic [31:0]            CoreAddr;
    logic [31:0]            CoreDataWr;
    logic [2:0]             CoreCtrl;
    logic                   CoreWr;
    logic                   CoreRd;
    logic                   SBFlush;
    logic [31:0]            CoreDataRd;
    logic                   CoreStall;
    logic                   SBEmpty;
    logic [$clog2(DEPTH):0] SBCount;
    logic [31:0]            DMAddress;
    logic [31:0]            DMDataWr;
    logic                   DMWr;
    logic [2:0]             DMCtrl;
    logic [31:0]            DMDataRd;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
    } ent_t;

    ent_t q[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .CoreAddr(CoreAddr), .CoreDataWr(CoreDataWr), .CoreCtrl(CoreCtrl),
        .CoreWr(CoreWr), .CoreRd(CoreRd), .SBFlush(SBFlush),
        .CoreDataRd(CoreDataRd), .CoreStall(CoreStall), .SBEmpty(SBEmpty), .SBCount(SBCount),
        .DMAddress(DMAddress), .DMDataWr(DMDataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
        .DMDataRd(DMDataRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef SB_FWD_EN
    function automatic logic [31:0] ext_ref(input logic [31:0] d, input logic [2:0] c);
        int nbytes;
        logic [31:0] mask;
        logic [31:0] v;
        nbytes = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v      = d & mask;
        if (!c[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction
`endif

    // One cycle: drive at the falling edge, check combinational outputs, advance the model.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                        input logic wr, input logic rd, input logic fl);
        logic [31:0] dmrd;
        logic [31:0] fv;
        logic [31:0] e_addr, e_data, e_rd;
        logic [2:0]  e_ctrl;
        logic        e_wr;
        bit          hz, fw, blk, drn, stall;
        int          j;
        dmrd       = $urandom;
        CoreAddr   = a;
        CoreDataWr = d;
        CoreCtrl   = c;
        CoreWr     = wr;
        CoreRd     = rd;
        SBFlush    = fl;
        DMDataRd   = dmrd;
        #2;
        hz = 0; fw = 0; fv = '0; j = -1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == a[31:2]) begin
                j = i;
                break;
            end
        end
        if (j >= 0) begin
`ifdef SB_FWD_EN
            if (q[j].a == a && q[j].c[1:0] == c[1:0]) begin
                fw = 1;
                fv = ext_ref(q[j].d, c);
            end else begin
                hz = 1;
            end
`else
            hz = 1;
`endif
        end
        if (!rd) begin
            hz = 0;
            fw = 0;
        end
        blk   = rd && (hz || (fl && q.size() != 0));
        drn   = q.size() != 0 && (rd ? blk : (!wr || q.size() == DEPTH || fl));
        stall = (rd && hz) || (fl && q.size() != 0);
        e_addr = '0; e_data = '0; e_ctrl = '0; e_wr = 1'b0;
        if (drn) begin
            e_addr = q[0].a; e_data = q[0].d; e_ctrl = q[0].c; e_wr = 1'b1;
        end else if (rd && !blk && !fw) begin
            e_addr = a; e_ctrl = c;
        end
        e_rd = (rd && !blk) ? (fw ? fv : dmrd) : 32'h0;
        chk("sbcount", 32'(SBCount), 32'(q.size()));
        chk("sbempty", 32'(SBEmpty), 32'(q.size() == 0));
        chk("stall", 32'(CoreStall), 32'(stall));
        chk("dmwr", 32'(DMWr), 32'(e_wr));
        chk("dmaddr", DMAddress, e_addr);
        chk("dmdata", DMDataWr, e_data);
        chk("dmctrl", 32'(DMCtrl), 32'(e_ctrl));
        chk("rddata", CoreDataRd, e_rd);
        if (drn) void'(q.pop_front());
        if (wr && !rd) q.push_back('{a: a, d: d, c: c});
        @(negedge clk);
    endtask

    task automatic idle();
        step(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0]  ctab [5];
        logic [2:0]  c;
        logic [31:0] a;
        int          r;
        total = 0;
        bad   = 0;
        ctab  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // reset: outputs forced quiet even with a load and fence requested
        rst        = 1'b1;
        CoreAddr   = 32'h100;
        CoreDataWr = 32'h5555_5555;
        CoreCtrl   = 3'b010;
        CoreWr     = 1'b1;
        CoreRd     = 1'b1;
        SBFlush    = 1'b1;
        DMDataRd   = 32'hABCD_1234;
        @(negedge clk);
        #2;
        chk("rst_count", 32'(SBCount), 32'h0);
        chk("rst_empty", 32'(SBEmpty), 32'h1);
        chk("rst_stall", 32'(CoreStall), 32'h0);
        chk("rst_dmwr", 32'(DMWr), 32'h0);
        chk("rst_dmaddr", DMAddress, 32'h0);
        chk("rst_rddata", CoreDataRd, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // single store drained on the first idle cycle
        step(32'h100, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // five back-to-back stores into a depth-4 buffer
        for (int i = 0; i < 5; i++) step(32'(4 * i), $urandom, 3'b010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();

        // byte store then signed and unsigned byte loads of the same address
        step(32'h20, 32'h0000_00F0, 3'b000, 1'b1, 1'b0, 1'b0);
        step(32'h20, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
        step(32'h20, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle();

        // halfword store then word load: stall, drain, then read memory
        step(32'h40, 32'h0000_1234, 3'b001, 1'b1, 1'b0, 1'b0);
        step(32'h40, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
        step(32'h40, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);

        // three stores then a held fence
        for (int i = 0; i < 3; i++) step(32'h80 + 32'(4 * i), $urandom, 3'b010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);

        // reset while draining with two entries buffered
        step(32'h200, 32'h1111_1111, 3'b010, 1'b1, 1'b0, 1'b0);
        step(32'h204, 32'h2222_2222, 3'b010, 1'b1, 1'b0, 1'b0);
        CoreWr  = 1'b0;
        CoreRd  = 1'b0;
        SBFlush = 1'b0;
        #2;
        chk("mid_dmwr_pre", 32'(DMWr), 32'h1);
        chk("mid_count_pre", 32'(SBCount), 32'h2);
        rst = 1'b1;
        #1;
        chk("mid_count_rst", 32'(SBCount), 32'h0);
        chk("mid_dmwr_rst", 32'(DMWr), 32'h0);
        chk("mid_empty_rst", 32'(SBEmpty), 32'h1);
        chk("mid_dmaddr_rst", DMAddress, 32'h0);
        q.delete();
        @(negedge clk);
        chk("mid_dmwr_hold", 32'(DMWr), 32'h0);
        rst = 1'b0;
        idle();
        idle();

        // random traffic on a small address window to provoke overlaps
        for (int n = 0; n < 400; n++) begin
            c = ctab[$urandom_range(0, 4)];
            a = 32'h100 | (32'($urandom_range(0, 3)) << 2);
            a = a | (32'($urandom_range(0, 3)) & ((c[1:0] == 2'b10) ? 32'h0 : (c[1:0] == 2'b01) ? 32'h2 : 32'h3));
            r = $urandom_range(0, 99);
            step(a, $urandom, c, r < 50, r >= 40 && r < 70, $urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < 5; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
